// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: ID->EX issue gate with scoreboard, EX->ID forwarding selects, MUL sequencing and branch flush.
// Ports: clk; rst (async, active-low); id_valid/id_opcode/id_funct3/id_rd/id_rs1/id_rs2 decoded instruction;
// wb_valid/wb_rd write-back; ex_br_taken taken-branch pulse; id_ready/issue handshake; fwd_rs1/fwd_rs2 selects;
// mul_start/mul_busy MUL sequencing; flush; pending scoreboard; stall_cnt saturating stall counter.
// Optional HZ_R0_ZERO_EN: r0 hardwired zero, never tracked, forwarded or hazarded.
module pipe_hazard_ctrl #(
  parameter int MUL_LAT     = 4,
  parameter int FLUSH_CYC   = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [1:0]             id_opcode,
  input  logic [2:0]             id_funct3,
  input  logic [2:0]             id_rd,
  input  logic [2:0]             id_rs1,
  input  logic [2:0]             id_rs2,
  input  logic                   wb_valid,
  input  logic [2:0]             wb_rd,
  input  logic                   ex_br_taken,
  output logic                   id_ready,
  output logic                   issue,
  output logic                   fwd_rs1,
  output logic                   fwd_rs2,
  output logic                   mul_start,
  output logic                   mul_busy,
  output logic                   flush,
  output logic [7:0]             pending,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {RUN, MUL, FLUSH} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [7:0] pending_nxt;
  logic reads1, reads2, writes, is_mul, hz1, hz2, nz1, nz2;
`ifdef HZ_R0_ZERO_EN
  localparam logic [7:0] TRACK = 8'hfe;
  assign nz1 = id_rs1 != 3'd0;
  assign nz2 = id_rs2 != 3'd0;
`else
  localparam logic [7:0] TRACK = 8'hff;
  assign nz1 = 1'b1;
  assign nz2 = 1'b1;
`endif
  assign reads1   = id_opcode != 2'b10;
  assign reads2   = id_opcode == 2'b01;
  assign writes   = id_opcode != 2'b00;
  assign is_mul   = id_opcode == 2'b01 && id_funct3 == 3'b111;
  assign fwd_rs1  = reads1 && nz1 && wb_valid && wb_rd == id_rs1;
  assign fwd_rs2  = reads2 && nz2 && wb_valid && wb_rd == id_rs2;
  assign hz1      = reads1 && pending[id_rs1] && !fwd_rs1;
  assign hz2      = reads2 && pending[id_rs2] && !fwd_rs2;
  assign id_ready = state == RUN && !ex_br_taken && !hz1 && !hz2;
  assign issue    = id_valid && id_ready;
  assign mul_busy = state == MUL;
  assign flush    = state == FLUSH;
  // set is OR-ed in after the clear so a same-cycle issue to the written-back register keeps it pending
  assign pending_nxt = ((pending & ~(wb_valid ? 8'(1) << wb_rd : 8'h00))
                       | (issue && writes ? 8'(1) << id_rd : 8'h00)) & TRACK;
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == RUN) begin
      if (ex_br_taken) begin
        state_nxt = FLUSH;
        cnt_nxt   = 4'(FLUSH_CYC - 1);
      end else if (issue && is_mul) begin
        state_nxt = MUL;
        cnt_nxt   = 4'(MUL_LAT - 1);
      end
    end else begin
      state_nxt = cnt == 4'd0 ? RUN : state;
      cnt_nxt   = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      cnt       <= 4'd0;
      pending   <= 8'h00;
      mul_start <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pending   <= pending_nxt;
      mul_start <= issue && is_mul;
      if (id_valid && !id_ready && !(&stall_cnt))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of issue gating, forwarding, scoreboard, MUL, flush and async reset.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic id_valid = 1'b0, wb_valid = 1'b0, ex_br_taken = 1'b0;
  logic [1:0] id_opcode = 2'd0;
  logic [2:0] id_funct3 = 3'd0, id_rd = 3'd0, id_rs1 = 3'd0, id_rs2 = 3'd0, wb_rd = 3'd0;
  logic id_ready, issue, fwd_rs1, fwd_rs2, mul_start, mul_busy, flush;
  logic [7:0] pending;
  logic [2:0] stall_cnt;
  int checks = 0, errors = 0;

  pipe_hazard_ctrl #(.MUL_LAT(4), .FLUSH_CYC(2), .STALL_CNT_W(3)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct3(id_funct3),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .ex_br_taken(ex_br_taken), .id_ready(id_ready), .issue(issue), .fwd_rs1(fwd_rs1),
    .fwd_rs2(fwd_rs2), .mul_start(mul_start), .mul_busy(mul_busy), .flush(flush),
    .pending(pending), .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [1:0] op, input logic [2:0] f3, input logic [2:0] rd,
                     input logic [2:0] r1, input logic [2:0] r2, input logic wv, input logic [2:0] wr,
                     input logic br);
    id_valid = v; id_opcode = op; id_funct3 = f3; id_rd = rd; id_rs1 = r1; id_rs2 = r2;
    wb_valid = wv; wb_rd = wr; ex_br_taken = br;
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    chk("rst_mul_busy", {7'd0, mul_busy}, 8'd0);
    chk("rst_flush", {7'd0, flush}, 8'd0);
    chk("rst_pending", pending, 8'h00);
    chk("rst_stall", {5'd0, stall_cnt}, 8'd0);
    chk("rst_ready", {7'd0, id_ready}, 8'd1);
    #9 rst = 1'b1;
    cyc();
    drv(0, 2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 0, 3'd0, 0);
    chk("idle_ready", {7'd0, id_ready}, 8'd1);
    chk("idle_issue", {7'd0, issue}, 8'd0);
    chk("idle_fwd", {6'd0, fwd_rs1, fwd_rs2}, 8'd0);
    drv(1, 2'b01, 3'd0, 3'd3, 3'd1, 3'd2, 0, 3'd0, 0);
    chk("op01_issue", {7'd0, issue}, 8'd1);
    cyc();
    chk("pend_r3", pending, 8'h08);
    chk("no_mul_start", {7'd0, mul_start}, 8'd0);
    drv(1, 2'b01, 3'd0, 3'd4, 3'd3, 3'd1, 0, 3'd0, 0);
    chk("raw_ready", {7'd0, id_ready}, 8'd0);
    chk("raw_issue", {7'd0, issue}, 8'd0);
    chk("raw_fwd1", {7'd0, fwd_rs1}, 8'd0);
    cyc();
    chk("stall_1", {5'd0, stall_cnt}, 8'd1);
    drv(1, 2'b01, 3'd0, 3'd4, 3'd3, 3'd1, 1, 3'd3, 0);
    chk("fwd1", {7'd0, fwd_rs1}, 8'd1);
    chk("fwd2_off", {7'd0, fwd_rs2}, 8'd0);
    chk("fwd_issue", {7'd0, issue}, 8'd1);
    cyc();
    chk("pend_wb3_set4", pending, 8'h10);
    chk("stall_hold", {5'd0, stall_cnt}, 8'd1);
    drv(1, 2'b01, 3'd7, 3'd5, 3'd1, 3'd2, 0, 3'd0, 0);
    chk("mul_issue", {7'd0, issue}, 8'd1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      drv(1, 2'b10, 3'd0, 3'd6, 3'd0, 3'd0, 0, 3'd0, i == 1);
      chk($sformatf("mul_busy_%0d", i), {7'd0, mul_busy}, 8'd1);
      chk($sformatf("mul_start_%0d", i), {7'd0, mul_start}, {7'd0, i == 0});
      chk($sformatf("mul_ready_%0d", i), {7'd0, id_ready}, 8'd0);
      chk($sformatf("mul_flush_%0d", i), {7'd0, flush}, 8'd0);
      chk($sformatf("mul_pend_%0d", i), pending, 8'h30);
      cyc();
    end
    drv(1, 2'b10, 3'd0, 3'd2, 3'd0, 3'd0, 1, 3'd2, 0);
    chk("mul_done", {7'd0, mul_busy}, 8'd0);
    chk("mul_start_once", {7'd0, mul_start}, 8'd0);
    chk("stall_5", {5'd0, stall_cnt}, 8'd5);
    chk("post_mul_issue", {7'd0, issue}, 8'd1);
    cyc();
    chk("set_wins", pending, 8'h34);
    drv(1, 2'b10, 3'd0, 3'd7, 3'd0, 3'd0, 0, 3'd0, 1);
    chk("br_ready", {7'd0, id_ready}, 8'd0);
    chk("br_issue", {7'd0, issue}, 8'd0);
    cyc();
    drv(1, 2'b10, 3'd0, 3'd7, 3'd0, 3'd0, 0, 3'd0, 0);
    chk("flush_0", {7'd0, flush}, 8'd1);
    chk("flush_pend", pending, 8'h34);
    chk("flush_ready", {7'd0, id_ready}, 8'd0);
    chk("stall_6", {5'd0, stall_cnt}, 8'd6);
    cyc();
    chk("flush_1", {7'd0, flush}, 8'd1);
    chk("stall_7", {5'd0, stall_cnt}, 8'd7);
    drv(1, 2'b01, 3'd0, 3'd1, 3'd0, 3'd5, 0, 3'd0, 0);
    cyc();
    chk("flush_end", {7'd0, flush}, 8'd0);
    chk("stall_sat", {5'd0, stall_cnt}, 8'd7);
    chk("hz2_ready", {7'd0, id_ready}, 8'd0);
    cyc();
    chk("stall_sat2", {5'd0, stall_cnt}, 8'd7);
    drv(1, 2'b00, 3'd0, 3'd0, 3'd1, 3'd4, 1, 3'd4, 0);
    chk("op00_no_rs2", {7'd0, id_ready}, 8'd1);
    chk("op00_fwd2", {7'd0, fwd_rs2}, 8'd0);
    cyc();
    chk("clr_r4", pending, 8'h24);
    drv(1, 2'b01, 3'd7, 3'd5, 3'd0, 3'd1, 0, 3'd0, 0);
    chk("mul2_issue", {7'd0, issue}, 8'd1);
    cyc();
    drv(0, 2'b00, 3'd0, 3'd0, 3'd0, 3'd0, 0, 3'd0, 0);
    chk("mul2_busy", {7'd0, mul_busy}, 8'd1);
    chk("mul2_pend", pending, 8'h24);
    #1 rst = 1'b0;
    #1;
    chk("arst_busy", {7'd0, mul_busy}, 8'd0);
    chk("arst_flush", {7'd0, flush}, 8'd0);
    chk("arst_pend", pending, 8'h00);
    chk("arst_stall", {5'd0, stall_cnt}, 8'd0);
    chk("arst_start", {7'd0, mul_start}, 8'd0);
    chk("arst_ready", {7'd0, id_ready}, 8'd1);
    rst = 1'b1;
    cyc();
    cyc();
    chk("post_rst_busy", {7'd0, mul_busy}, 8'd0);
    chk("post_rst_pend", pending, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
